tblock_dispatcher: RTL and testbench
====================================

TBLOCK_DISPATCHER -- requirements
Module: tblock_dispatcher

Interface
REQ-001 SHALL have parameter PcWidth, default 32, program counter width.
REQ-002 SHALL have parameter AddressWidth, default 32, data/parameter address width.
REQ-003 SHALL have parameter TblockIdxBits, default 4, block index width; a kernel has at most 2^TblockIdxBits blocks.
REQ-004 SHALL have parameter TblockIdBits, default 4, block id width; at most 2^TblockIdBits blocks in flight.
REQ-005 SHALL have ports, in this order:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_valid_i  in  1  kernel launch request.
- start_ready_o  out  1  launch accepted.
- start_pc_i  in  PcWidth  kernel entry PC.
- start_dp_addr_i  in  AddressWidth  data/parameter address.
- start_num_blocks_i  in  TblockIdxBits+1  number of blocks.
- done_valid_o  out  1  kernel complete.
- done_ready_i  in  1  completion consumed.
- warp_free_i  in  1  compute unit can take a block.
- allocate_warp_o  out  1  block allocation request.
- allocate_pc_o  out  PcWidth  block PC.
- allocate_dp_addr_o  out  AddressWidth  block dp address.
- allocate_tblock_idx_o  out  TblockIdxBits  block index.
- allocate_tblock_id_o  out  TblockIdBits  in-flight id.
- tblock_done_i  in  1  block completion valid.
- tblock_done_id_i  in  TblockIdBits  completed block id.
- tblock_done_ready_o  out  1  completion accepted.

Function
REQ-006 SHALL implement FSM states IDLE, DISPATCH, DRAIN, DONE.
REQ-007 SHALL assert start_ready_o only in IDLE; on start_valid_i&&start_ready_o, latch pc, dp_addr and num_blocks, clear the dispatched count, and go to DONE if num_blocks==0, else to DISPATCH.
REQ-008 SHALL assert allocate_warp_o only in DISPATCH, only while dispatched<num_blocks and at least one id is free.
REQ-009 SHALL treat an allocation as fired when allocate_warp_o&&warp_free_i; allocate_warp_o SHALL NOT depend combinationally on warp_free_i.
REQ-010 SHALL drive allocate_pc_o and allocate_dp_addr_o from the latched values, and allocate_tblock_idx_o from dispatched[TblockIdxBits-1:0].
REQ-011 SHALL drive allocate_tblock_id_o as the lowest-numbered free id in the registered free mask.
REQ-012 On a fired allocation, SHALL mark that id busy, increment dispatched, and increment the outstanding count.
REQ-013 SHALL assert tblock_done_ready_o in DISPATCH and DRAIN only.
REQ-014 On tblock_done_i&&tblock_done_ready_o, SHALL mark tblock_done_id_i free and decrement the outstanding count.
REQ-015 On an allocation and a completion in the same cycle, SHALL leave the outstanding count unchanged.
REQ-016 An id freed in cycle N SHALL become allocatable in cycle N+1, not in cycle N.
REQ-017 SHALL move DISPATCH->DRAIN in the cycle the last allocation fires (dispatched reaches num_blocks).
REQ-018 SHALL move DRAIN->DONE when the next-state outstanding count is 0.
REQ-019 SHALL assert done_valid_o only in DONE, hold it until done_ready_i, then return to IDLE.
REQ-020 SHALL size the outstanding counter at TblockIdBits+1 bits; it SHALL never wrap, because at full count no id is free (REQ-008).
REQ-021 A completion carrying an id that is not busy SHALL be a simulation assertion error and SHALL leave the state unchanged.
REQ-022 A completion in IDLE or DONE SHALL NOT be accepted.

Reset
REQ-023 On rst_i at a clock edge, SHALL enter IDLE with all ids free, dispatched=0, outstanding=0 and latched fields=0.
REQ-024 After reset, outputs SHALL be: start_ready_o=1, done_valid_o=0, allocate_warp_o=0, tblock_done_ready_o=0, allocate_* data=0.
REQ-025 Reset mid-kernel SHALL abandon all in-flight blocks, with no done_valid_o for them.

Structure
REQ-026 SHALL place the FSM state enum in the shared compute-unit package.
REQ-027 SHALL use the common_cells lzc sub-module (trailing-zero mode) on the free mask for first-free-id selection.
REQ-028 SHALL use registers only for state, free mask, dispatched, outstanding and latched launch fields.

Verification
REQ-029 Launch num_blocks=3, pc=0x100, warp_free_i=1, immediate completions -> allocations with idx 0,1,2; each block carries pc=0x100; done_valid_o=1 after the last completion.
REQ-030 Launch num_blocks=0 -> done_valid_o=1 one cycle after the launch handshake, with no allocation.
REQ-031 TblockIdBits=2, num_blocks=8, no completions -> exactly 4 allocations with ids 0..3, then allocate_warp_o=0; completing id 2 -> next allocation (idx 4) uses id 2.
REQ-032 warp_free_i=0 for 10 cycles -> allocate_warp_o stays 1 with stable pc, dp_addr, idx and id, and no count changes.
REQ-033 Allocation and completion of different ids in the same cycle -> outstanding count unchanged; a freed id is not reused in the same cycle.
REQ-034 rst_i asserted in DRAIN with 2 blocks outstanding -> IDLE next cycle, start_ready_o=1, done_valid_o never asserted.

Source files
------------

// File: rtl/tblock_dispatcher_pkg.sv
// Shared compute-unit definitions used by the thread-block dispatcher.
package tblock_dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } tbd_state_e;

endpackage

// File: rtl/tblock_dispatcher_lzc.sv
// Zero counter: Mode=0 counts trailing zeros (index of lowest set bit),
// Mode=1 counts leading zeros. empty_o flags an all-zero input.
module tblock_dispatcher_lzc #(
  parameter int unsigned Width = 16,
  parameter bit          Mode  = 1'b0
) (
  input  logic [Width-1:0]         in_i,
  output logic [$clog2(Width)-1:0] cnt_o,
  output logic                     empty_o
);

  localparam int unsigned CntWidth = $clog2(Width);

  // Later loop iterations win, so the scan order picks the bit nearest the counted end.
  always_comb begin
    int pos;
    pos     = 0;
    cnt_o   = '0;
    empty_o = ~|in_i;
    for (int i = 0; i < int'(Width); i++) begin
      pos = Mode ? i : int'(Width) - 1 - i;
      if (in_i[pos]) begin
        cnt_o = Mode ? CntWidth'(int'(Width) - 1 - pos) : CntWidth'(pos);
      end
    end
  end

endmodule

// File: rtl/tblock_dispatcher.sv
// Kernel launcher: hands out thread blocks to the compute unit under a pool of
// in-flight ids, then reports kernel completion once every block has retired.
module tblock_dispatcher #(
  parameter int unsigned PcWidth       = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TblockIdxBits = 4,
  parameter int unsigned TblockIdBits  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_valid_i,
  output logic                      start_ready_o,
  input  logic [PcWidth-1:0]        start_pc_i,
  input  logic [AddressWidth-1:0]   start_dp_addr_i,
  input  logic [TblockIdxBits:0]    start_num_blocks_i,
  output logic                      done_valid_o,
  input  logic                      done_ready_i,
  input  logic                      warp_free_i,
  output logic                      allocate_warp_o,
  output logic [PcWidth-1:0]        allocate_pc_o,
  output logic [AddressWidth-1:0]   allocate_dp_addr_o,
  output logic [TblockIdxBits-1:0]  allocate_tblock_idx_o,
  output logic [TblockIdBits-1:0]   allocate_tblock_id_o,
  input  logic                      tblock_done_i,
  input  logic [TblockIdBits-1:0]   tblock_done_id_i,
  output logic                      tblock_done_ready_o
);

  import tblock_dispatcher_pkg::*;

  localparam int unsigned NumIds = 2 ** TblockIdBits;
  localparam int unsigned CntW   = TblockIdBits + 1;
  localparam int unsigned DispW  = TblockIdxBits + 1;

  tbd_state_e              state_q, state_d;
  logic [NumIds-1:0]       free_q, free_d;
  logic [DispW-1:0]        dispatched_q, dispatched_d;
  logic [DispW-1:0]        num_blocks_q, num_blocks_d;
  logic [CntW-1:0]         outstanding_q, outstanding_d;
  logic [PcWidth-1:0]      pc_q, pc_d;
  logic [AddressWidth-1:0] dp_addr_q, dp_addr_d;

  logic [TblockIdBits-1:0] first_free_id;
  logic                    no_free_id;
  logic                    start_fire;
  logic                    alloc_fire;
  logic                    done_fire;
  logic                    done_legal;

  tblock_dispatcher_lzc #(
    .Width (NumIds),
    .Mode  (1'b0)
  ) u_free_lzc (
    .in_i    (free_q),
    .cnt_o   (first_free_id),
    .empty_o (no_free_id)
  );

  assign start_fire = start_valid_i && start_ready_o;
  assign alloc_fire = allocate_warp_o && warp_free_i;
  assign done_fire  = tblock_done_i && tblock_done_ready_o;
  // A completion for an id that is already free is dropped rather than corrupting the count.
  assign done_legal = done_fire && !free_q[tblock_done_id_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      free_q        <= '1;
      dispatched_q  <= '0;
      num_blocks_q  <= '0;
      outstanding_q <= '0;
      pc_q          <= '0;
      dp_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      free_q        <= free_d;
      dispatched_q  <= dispatched_d;
      num_blocks_q  <= num_blocks_d;
      outstanding_q <= outstanding_d;
      pc_q          <= pc_d;
      dp_addr_q     <= dp_addr_d;
    end
  end

  always_comb begin
    free_d        = free_q;
    dispatched_d  = dispatched_q;
    num_blocks_d  = num_blocks_q;
    outstanding_d = outstanding_q;
    pc_d          = pc_q;
    dp_addr_d     = dp_addr_q;
    if (start_fire) begin
      pc_d         = start_pc_i;
      dp_addr_d    = start_dp_addr_i;
      num_blocks_d = start_num_blocks_i;
      dispatched_d = '0;
    end
    if (alloc_fire) begin
      free_d[first_free_id] = 1'b0;
      dispatched_d          = dispatched_q + DispW'(1);
    end
    if (done_legal) begin
      free_d[tblock_done_id_i] = 1'b1;
    end
    case ({alloc_fire, done_legal})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_valid_i) state_d = (start_num_blocks_i == '0) ? DONE : DISPATCH;
      DISPATCH: if (alloc_fire && (dispatched_d == num_blocks_q)) state_d = DRAIN;
      DRAIN:    if (outstanding_d == '0) state_d = DONE;
      DONE:     if (done_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready_o         = (state_q == IDLE);
    done_valid_o          = (state_q == DONE);
    allocate_warp_o       = (state_q == DISPATCH) && (dispatched_q < num_blocks_q) && !no_free_id;
    tblock_done_ready_o   = (state_q == DISPATCH) || (state_q == DRAIN);
    allocate_pc_o         = pc_q;
    allocate_dp_addr_o    = dp_addr_q;
    allocate_tblock_idx_o = dispatched_q[TblockIdxBits-1:0];
    allocate_tblock_id_o  = first_free_id;
  end

  a_done_id_busy : assert property (@(posedge clk_i) disable iff (rst_i)
    done_fire |-> !free_q[tblock_done_id_i]);

endmodule

// File: tb/tb_tblock_dispatcher.sv
// Randomized scoreboard bench for tblock_dispatcher with a transaction-level model.
module tb_tblock_dispatcher;

  localparam int PcW   = 32;
  localparam int AdrW  = 32;
  localparam int IdxB  = 4;
  localparam int IdB   = 2;
  localparam int NIds  = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_valid_i = 1'b0;
  logic            start_ready_o;
  logic [PcW-1:0]  start_pc_i = '0;
  logic [AdrW-1:0] start_dp_addr_i = '0;
  logic [IdxB:0]   start_num_blocks_i = '0;
  logic            done_valid_o;
  logic            done_ready_i = 1'b0;
  logic            warp_free_i = 1'b0;
  logic            allocate_warp_o;
  logic [PcW-1:0]  allocate_pc_o;
  logic [AdrW-1:0] allocate_dp_addr_o;
  logic [IdxB-1:0] allocate_tblock_idx_o;
  logic [IdB-1:0]  allocate_tblock_id_o;
  logic            tblock_done_i = 1'b0;
  logic [IdB-1:0]  tblock_done_id_i = '0;
  logic            tblock_done_ready_o;

  tblock_dispatcher #(
    .PcWidth(PcW), .AddressWidth(AdrW), .TblockIdxBits(IdxB), .TblockIdBits(IdB)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
    .start_pc_i(start_pc_i), .start_dp_addr_i(start_dp_addr_i),
    .start_num_blocks_i(start_num_blocks_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .warp_free_i(warp_free_i), .allocate_warp_o(allocate_warp_o),
    .allocate_pc_o(allocate_pc_o), .allocate_dp_addr_o(allocate_dp_addr_o),
    .allocate_tblock_idx_o(allocate_tblock_idx_o), .allocate_tblock_id_o(allocate_tblock_id_o),
    .tblock_done_i(tblock_done_i), .tblock_done_id_i(tblock_done_id_i),
    .tblock_done_ready_o(tblock_done_ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PcW-1:0]  pc;
    logic [AdrW-1:0] dp;
    int              idx;
  } alloc_t;

  // Reference model: expected block stream, busy ids, kernel activity.
  alloc_t exp_q[$];
  bit     busy_m[NIds];
  bit     active_m;
  bit     start_seen;
  bit     mon_en;
  int     kern_allocs;
  int     last_alloc_id;
  int     last_alloc_idx;
  int     checks;
  int     errors;

  // Driver knobs (percent probabilities, -1 = random).
  int p_warp = 100;
  int p_done = 100;
  int p_dready = 100;
  int force_warp = -1;
  int force_done_id = -1;

  function automatic int nbusy();
    int n;
    n = 0;
    for (int i = 0; i < NIds; i++) n += int'(busy_m[i]);
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NIds; i++) if (!busy_m[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compares every cycle and on every handshake.
  int     lf_m;
  bit     exp_done_m;
  bit     alloc_m;
  alloc_t e_m;
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      for (int i = 0; i < NIds; i++) busy_m[i] = 1'b0;
      active_m = 1'b0;
    end else if (mon_en) begin
      exp_done_m = active_m && exp_q.size() == 0 && nbusy() == 0;
      chk("start_ready", start_ready_o, !active_m);
      chk("allocate_warp", allocate_warp_o, active_m && exp_q.size() > 0 && nbusy() < NIds);
      chk("done_valid", done_valid_o, exp_done_m);
      chk("tblock_done_ready", tblock_done_ready_o, active_m && !exp_done_m);
      lf_m    = lowest_free();
      alloc_m = allocate_warp_o && warp_free_i;
      if (alloc_m) begin
        if (exp_q.size() == 0) begin
          chk("alloc_unexpected", allocate_warp_o, 1'b0);
        end else begin
          e_m = exp_q.pop_front();
          chk("alloc_pc", allocate_pc_o, e_m.pc);
          chk("alloc_dp", allocate_dp_addr_o, e_m.dp);
          chk("alloc_idx", allocate_tblock_idx_o, e_m.idx);
          chk("alloc_id", allocate_tblock_id_o, lf_m);
          $display("alloc idx=%0d id=%0d pc=%h dp=%h", allocate_tblock_idx_o,
                   allocate_tblock_id_o, allocate_pc_o, allocate_dp_addr_o);
        end
        last_alloc_id  = int'(allocate_tblock_id_o);
        last_alloc_idx = int'(allocate_tblock_idx_o);
        kern_allocs++;
      end
      if (tblock_done_i && active_m && !exp_done_m) begin
        busy_m[tblock_done_id_i] = 1'b0;
        $display("complete id=%0d", tblock_done_id_i);
      end
      if (alloc_m && lf_m >= 0) busy_m[lf_m] = 1'b1;
      if (start_valid_i && !active_m) begin
        active_m    = 1'b1;
        start_seen  = 1'b1;
        kern_allocs = 0;
        for (int i = 0; i < int'(start_num_blocks_i); i++)
          exp_q.push_back('{pc: start_pc_i, dp: start_dp_addr_i, idx: i});
        $display("launch n=%0d pc=%h dp=%h", start_num_blocks_i, start_pc_i, start_dp_addr_i);
      end
      if (exp_done_m && done_ready_i) begin
        active_m = 1'b0;
        $display("kernel done");
      end
    end
  end

  task automatic step();
    int cand[$];
    @(posedge clk_i);
    #1;
    warp_free_i   = (force_warp >= 0) ? force_warp[0] : ($urandom_range(99) < p_warp);
    done_ready_i  = ($urandom_range(99) < p_dready);
    tblock_done_i = 1'b0;
    tblock_done_id_i = '0;
    if (force_done_id >= 0) begin
      tblock_done_i    = 1'b1;
      tblock_done_id_i = IdB'(force_done_id);
      force_done_id    = -1;
    end else if (nbusy() > 0 && $urandom_range(99) < p_done) begin
      for (int i = 0; i < NIds; i++) if (busy_m[i]) cand.push_back(i);
      tblock_done_i    = 1'b1;
      tblock_done_id_i = IdB'(cand[$urandom_range(cand.size() - 1)]);
    end
  endtask

  task automatic launch(input int n, input logic [PcW-1:0] pc, input logic [AdrW-1:0] dp);
    start_pc_i         = pc;
    start_dp_addr_i    = dp;
    start_num_blocks_i = (IdxB + 1)'(n);
    start_valid_i      = 1'b1;
    start_seen         = 1'b0;
    for (int i = 0; i < 50 && !start_seen; i++) step();
    start_valid_i = 1'b0;
    chk("launch_accepted", start_seen, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && active_m; i++) step();
    chk("kernel_finished", active_m, 1'b0);
  endtask

  logic [PcW-1:0]  ref_pc;
  logic [AdrW-1:0] ref_dp;
  logic [IdxB-1:0] ref_idx;
  logic [IdB-1:0]  ref_id;

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    repeat (3) step();
    chk("rst_start_ready", start_ready_o, 1'b1);
    chk("rst_done_valid", done_valid_o, 1'b0);
    chk("rst_alloc_warp", allocate_warp_o, 1'b0);
    chk("rst_done_ready", tblock_done_ready_o, 1'b0);
    chk("rst_alloc_pc", allocate_pc_o, '0);
    chk("rst_alloc_dp", allocate_dp_addr_o, '0);
    chk("rst_alloc_idx", allocate_tblock_idx_o, '0);
    chk("rst_alloc_id", allocate_tblock_id_o, '0);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    step();

    // Three blocks, always-free warps, immediate completions.
    p_warp = 100; p_done = 100; p_dready = 100;
    launch(3, 32'h100, 32'h2000);
    wait_idle();
    chk("three_block_allocs", kern_allocs, 3);

    // Empty kernel: completion one cycle after the handshake, no allocation.
    p_dready = 0;
    launch(0, 32'h400, 32'h0);
    chk("empty_done_valid", done_valid_o, 1'b1);
    chk("empty_no_alloc", kern_allocs, 0);
    p_dready = 100;
    wait_idle();

    // Id pool exhaustion, then reuse of a freed id one cycle later.
    p_done = 0;
    launch(8, 32'h800, 32'h3000);
    repeat (12) step();
    chk("pool_allocs", kern_allocs, 4);
    chk("pool_warp_low", allocate_warp_o, 1'b0);
    force_done_id = 2;
    repeat (3) step();
    chk("reuse_id", last_alloc_id, 2);
    chk("reuse_idx", last_alloc_idx, 4);
    p_done = 100;
    wait_idle();

    // Compute unit stalled: request and its payload hold steady.
    force_warp = 0;
    launch(5, 32'hCAFE_0000, 32'hBEEF_0000);
    ref_pc = allocate_pc_o; ref_dp = allocate_dp_addr_o;
    ref_idx = allocate_tblock_idx_o; ref_id = allocate_tblock_id_o;
    chk("stall_ref_pc", ref_pc, 32'hCAFE_0000);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_warp", allocate_warp_o, 1'b1);
      chk("stall_payload", {allocate_pc_o, allocate_dp_addr_o}, {ref_pc, ref_dp});
      chk("stall_idx_id", {allocate_tblock_idx_o, allocate_tblock_id_o}, {ref_idx, ref_id});
    end
    chk("stall_no_allocs", kern_allocs, 0);
    force_warp = -1;
    wait_idle();

    // Randomized kernels with random handshake pressure.
    for (int k = 0; k < 40; k++) begin
      p_warp   = int'($urandom_range(100, 30));
      p_done   = int'($urandom_range(90, 20));
      p_dready = int'($urandom_range(100, 30));
      launch(int'($urandom_range(16)), $urandom, $urandom);
      wait_idle();
    end

    // Reset while draining two outstanding blocks.
    p_warp = 100; p_done = 0; p_dready = 100;
    launch(2, 32'h1234, 32'h5678);
    for (int i = 0; i < 50 && kern_allocs < 2; i++) step();
    step();
    chk("drain_outstanding", nbusy(), 2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("midrst_start_ready", start_ready_o, 1'b1);
    chk("midrst_done_valid", done_valid_o, 1'b0);
    chk("midrst_alloc_pc", allocate_pc_o, '0);
    p_done = 100;
    force_done_id = 1;
    repeat (10) step();
    launch(2, 32'h9000, 32'h9100);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
